hazard_ctrl: RTL and testbench

- Pipeline hazard sequencer for the 5-stage mini CPU.
- Generates the stall/redirect controls consumed by pc_gen (pc_stall -> hazard_pcStall, pc_from_taken -> hazard_pcFromTaken) and the stall/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates between data-memory wait, branch/jump redirect, load-use interlock and instruction-fetch wait. Holds multi-cycle state for flush shadow and memory-wait timeout.

---
 rtl/hazard_ctrl_if.sv | 64 ++++++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle between the CPU pipeline (master) and hazard_ctrl (slave).
// HAZARD_PERF_EN adds the performance counter outputs.
interface hazard_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_valid;
  logic [4:0] ex_rd_addr;
  logic       ex_mem_read;
  logic       ex_branch;
  logic [1:0] ex_jump;
  logic       ex_branch_taken;
  logic       ex_pred_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       imem_ready;
  logic       pc_stall;
  logic       pc_from_taken;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_stall;
  logic       mem_wb_flush;
  logic       stall_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
  logic [31:0] perf_load_use;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_addr,
           ex_mem_read, ex_branch, ex_jump, ex_branch_taken, ex_pred_taken,
           dmem_req, dmem_ready, imem_ready,
    input  pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, stall_timeout,
           perf_stall_cycles, perf_redirects, perf_load_use
  );
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_addr,
           ex_mem_read, ex_branch, ex_jump, ex_branch_taken, ex_pred_taken,
           dmem_req, dmem_ready, imem_ready,
    output pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, stall_timeout,
           perf_stall_cycles, perf_redirects, perf_load_use
  );
`else
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_addr,
           ex_mem_read, ex_branch, ex_jump, ex_branch_taken, ex_pred_taken,
           dmem_req, dmem_ready, imem_ready,
    input  pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, stall_timeout
  );
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_addr,
           ex_mem_read, ex_branch, ex_jump, ex_branch_taken, ex_pred_taken,
           dmem_req, dmem_ready, imem_ready,
    output pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, stall_timeout
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: dmem wait > redirect > flush shadow > load-use > imem wait.
// Optional HAZARD_PERF_EN adds stall/redirect/load-use event counters.
//
// state   | meaning
// S_RUN   | normal operation, no flush shadow pending
// S_FLUSH | post-redirect shadow, IF/ID flushed while r_flush_cnt > 0
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t      r_state;
  logic [2:0]  r_flush_cnt;
  logic [15:0] r_wait_cnt;
  logic        r_timeout;

  logic w_mem_wait, w_redirect, w_load_use, w_rs1_hit, w_rs2_hit, w_lu_win;
  logic w_pc_stall, w_pc_from_taken, w_if_id_stall, w_if_id_flush;
  logic w_id_ex_stall, w_id_ex_flush, w_ex_mem_stall, w_mem_wb_flush;

  assign w_mem_wait = bus.dmem_req & ~bus.dmem_ready;
  assign w_redirect = bus.ex_valid &
                      ((bus.ex_branch & (bus.ex_branch_taken != bus.ex_pred_taken)) |
                       bus.ex_jump[1] | (bus.ex_jump[0] & ~bus.ex_pred_taken));
  assign w_rs1_hit  = bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr);
  assign w_rs2_hit  = bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr);
  assign w_load_use = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd_addr != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);
  assign w_lu_win   = w_load_use & ~w_mem_wait & ~w_redirect & (r_state == S_RUN);

  always_comb begin
    w_pc_stall      = 1'b0;
    w_pc_from_taken = 1'b0;
    w_if_id_stall   = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_stall  = 1'b0;
    w_mem_wb_flush  = 1'b0;
    if (reset_n) begin
      if (w_mem_wait) begin
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_stall  = 1'b1;
        w_ex_mem_stall = 1'b1;
        w_mem_wb_flush = 1'b1;
      end else if (w_redirect) begin
        w_pc_from_taken = 1'b1;
        w_if_id_flush   = 1'b1;
        w_id_ex_flush   = 1'b1;
      end else if (r_state == S_FLUSH) begin
        w_if_id_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (!bus.imem_ready) begin
        w_pc_stall    = 1'b1;
        w_if_id_flush = 1'b1;
      end
    end
  end

  assign bus.pc_stall      = w_pc_stall;
  assign bus.pc_from_taken = w_pc_from_taken;
  assign bus.if_id_stall   = w_if_id_stall;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_stall   = w_id_ex_stall;
  assign bus.id_ex_flush   = w_id_ex_flush;
  assign bus.ex_mem_stall  = w_ex_mem_stall;
  assign bus.mem_wb_flush  = w_mem_wb_flush;
  assign bus.stall_timeout = r_timeout & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 3'd0;
      r_wait_cnt  <= 16'd0;
      r_timeout   <= 1'b0;
    end else if (w_mem_wait) begin
      // Counter saturates at the threshold; the flush shadow is frozen meanwhile.
      if (r_wait_cnt != 16'(MEM_TIMEOUT)) r_wait_cnt <= r_wait_cnt + 16'd1;
      if (r_wait_cnt + 16'd1 == 16'(MEM_TIMEOUT)) r_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= 16'd0;
      if (w_redirect) begin
        if (FLUSH_CYCLES > 1) begin
          r_state     <= S_FLUSH;
          r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
        end else begin
          r_state     <= S_RUN;
          r_flush_cnt <= 3'd0;
        end
      end else if (r_state == S_FLUSH) begin
        r_flush_cnt <= r_flush_cnt - 3'd1;
        if (r_flush_cnt == 3'd1) r_state <= S_RUN;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall, r_perf_redir, r_perf_lu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= 32'd0;
      r_perf_redir <= 32'd0;
      r_perf_lu    <= 32'd0;
    end else begin
      if (w_pc_stall) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_redirect & ~w_mem_wait) r_perf_redir <= r_perf_redir + 32'd1;
      if (w_lu_win) r_perf_lu <= r_perf_lu + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_redirects    = r_perf_redir;
  assign bus.perf_load_use     = r_perf_lu;
`else
  logic w_unused_lu;
  assign w_unused_lu = w_lu_win;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=8): rule-level model
// compared every negedge, plus directed vectors with literal expectations.
module tb_hazard_ctrl;

  localparam int FC     = 3;
  localparam int MEM_TO = 8;

  // {pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //  ex_mem_stall, mem_wb_flush, stall_timeout}
  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] LU   = 9'b101001000;
  localparam logic [8:0] RD   = 9'b010101000;
  localparam logic [8:0] FL   = 9'b000100000;
  localparam logic [8:0] MW   = 9'b101010110;
  localparam logic [8:0] IM   = 9'b100100000;
  localparam logic [8:0] TO   = 9'b000000001;

  logic clk;
  logic reset_n;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   done    = 0;

  int m_shadow  = 0;
  int m_waited  = 0;
  bit m_timeout = 0;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] dut_out;
  assign dut_out = {bus.pc_stall, bus.pc_from_taken, bus.if_id_stall, bus.if_id_flush,
                    bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush,
                    bus.stall_timeout};

  function automatic bit f_mem_wait();
    return bus.dmem_req && !bus.dmem_ready;
  endfunction

  function automatic bit f_redirect();
    bit mispred, jr, jd;
    mispred = bus.ex_branch && (bus.ex_branch_taken != bus.ex_pred_taken);
    jr      = bus.ex_jump[1];
    jd      = bus.ex_jump[0] && !bus.ex_pred_taken;
    return bus.ex_valid && (mispred || jr || jd);
  endfunction

  function automatic bit f_load_use();
    bit hit;
    hit = (bus.id_uses_rs1 && bus.id_rs1_addr == bus.ex_rd_addr) ||
          (bus.id_uses_rs2 && bus.id_rs2_addr == bus.ex_rd_addr);
    return bus.ex_valid && bus.ex_mem_read && bus.ex_rd_addr != 5'd0 && hit;
  endfunction

  function automatic logic [8:0] model_out();
    logic [8:0] e;
    e = ZERO;
    if (!reset_n) return ZERO;
    if (f_mem_wait())        e = MW;
    else if (f_redirect())   e = RD;
    else if (m_shadow > 0)   e = FL;
    else if (f_load_use())   e = LU;
    else if (!bus.imem_ready) e = IM;
    e[0] = m_timeout;
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_shadow  <= 0;
      m_waited  <= 0;
      m_timeout <= 0;
    end else if (f_mem_wait()) begin
      m_waited <= m_waited + 1;
      if (m_waited + 1 >= MEM_TO) m_timeout <= 1;
    end else begin
      m_waited <= 0;
      if (f_redirect())      m_shadow <= FC - 1;
      else if (m_shadow > 0) m_shadow <= m_shadow - 1;
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (!done) check("model", dut_out, model_out());
  end

  task automatic set_idle();
    bus.id_rs1_addr     = 5'd0;
    bus.id_rs2_addr     = 5'd0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_valid        = 1'b0;
    bus.ex_rd_addr      = 5'd0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_branch       = 1'b0;
    bus.ex_jump         = 2'b00;
    bus.ex_branch_taken = 1'b0;
    bus.ex_pred_taken   = 1'b0;
    bus.dmem_req        = 1'b0;
    bus.dmem_ready      = 1'b0;
    bus.imem_ready      = 1'b1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input logic [8:0] exp);
    #2;
    check(name, dut_out, exp);
  endtask

  task automatic drive_mispred();
    bus.ex_valid        = 1'b1;
    bus.ex_branch       = 1'b1;
    bus.ex_branch_taken = 1'b1;
    bus.ex_pred_taken   = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd);
    bus.ex_valid    = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd_addr  = rd;
    bus.id_rs1_addr = rd;
    bus.id_uses_rs1 = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    bus.imem_ready = 1'b0;
    drive_mispred();
    probe("reset_out", ZERO);
    next(); next();
    reset_n = 1'b1;
    set_idle();
    probe("idle", ZERO);

    // Load-use interlock, one cycle
    next(); drive_load_use(5'd5);               probe("lu_rs1", LU);
    next(); set_idle();                          probe("lu_clear", ZERO);
    next(); bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd_addr = 5'd7;
            bus.id_rs1_addr = 5'd7; bus.id_rs2_addr = 5'd7; bus.id_uses_rs2 = 1;
                                                 probe("lu_rs2", LU);
    next(); set_idle(); bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd_addr = 5'd9;
            bus.id_rs1_addr = 5'd9;              probe("lu_unused", ZERO);
    next(); set_idle(); drive_load_use(5'd0);    probe("lu_rd0", ZERO);

    // Branch mispredict with three-cycle flush shadow
    next(); set_idle(); drive_mispred();         probe("mispred_c0", RD);
    next(); set_idle();                          probe("mispred_c1", FL);
    next();                                      probe("mispred_c2", FL);
    next();                                      probe("mispred_c3", ZERO);
    next(); bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_branch_taken = 1;
            bus.ex_pred_taken = 1;               probe("pred_ok", ZERO);
    next(); set_idle(); bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_pred_taken = 1;
                                                 probe("mispred_nt", RD);
    next(); set_idle(); drive_load_use(5'd3);    probe("lu_in_shadow", FL);
    next(); set_idle(); next();
    next(); bus.ex_valid = 1; bus.ex_jump = 2'b01; bus.ex_pred_taken = 1;
                                                 probe("jdir_pred", ZERO);
    next(); bus.ex_pred_taken = 0;               probe("jdir_unpred", RD);
    next(); set_idle(); next(); next();

    // Register jump together with load-use: redirect only
    next(); bus.ex_jump = 2'b10; drive_load_use(5'd5);
                                                 probe("jreg_lu", RD);
    next(); set_idle();                          probe("jreg_c1", FL);
    next();                                      probe("jreg_c2", FL);
    next();                                      probe("jreg_c3", ZERO);

    // dmem wait defers a pending redirect
    next(); bus.dmem_req = 1; bus.dmem_ready = 0; drive_mispred();
    for (int i = 0; i < 4; i++) begin
      probe("dmem_freeze", MW);
      next();
    end
    bus.dmem_ready = 1;                          probe("dmem_release", RD);
    next(); set_idle(); next(); next();

    // dmem wait inside the flush shadow freezes it
    next(); drive_mispred();                     probe("fl_redir", RD);
    next(); set_idle(); bus.dmem_req = 1;        probe("fl_wait1", MW);
    next();                                      probe("fl_wait2", MW);
    next(); bus.dmem_req = 0;                    probe("fl_resume1", FL);
    next();                                      probe("fl_resume2", FL);
    next();                                      probe("fl_done", ZERO);

    // Sticky timeout after 8 wait cycles
    next(); bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) probe("to_before", MW);
      if (i == 8) probe("to_set", MW | TO);
      next();
    end
    bus.dmem_ready = 1;                          probe("to_sticky", TO);
    next(); set_idle();                          probe("to_sticky_idle", TO);
    next(); reset_n = 1'b0;                      probe("to_reset", ZERO);
    next(); reset_n = 1'b1;                      probe("to_cleared", ZERO);

    // Instruction fetch wait
    next(); bus.imem_ready = 0;                  probe("imem_w1", IM);
    next();                                      probe("imem_w2", IM);
    next(); set_idle();                          probe("imem_done", ZERO);

    // Reset in the middle of the flush shadow
    next(); drive_mispred();                     probe("rf_redir", RD);
    next(); set_idle(); bus.imem_ready = 0;      probe("rf_shadow_imem", FL);
    next(); reset_n = 1'b0; drive_load_use(5'd4); probe("rf_reset", ZERO);
    next(); reset_n = 1'b1; set_idle();          probe("rf_run", ZERO);
    next(); next();

    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
